// File: rtl/keypad_digit_buffer.sv
// Matrix keypad scanner with column synchroniser, press/release debounce,
// multi-key rejection and a shift-in digit history for the display multiplexer.
module keypad_digit_buffer #(
  parameter int                      NUM_DIGITS      = 2,
  parameter int                      ROWS            = 4,
  parameter int                      COLS            = 4,
  parameter int                      SCAN_DIV        = 1000,
  parameter int                      DEBOUNCE_CYCLES = 20000,
  parameter logic [ROWS*COLS*4-1:0]  KEYMAP          = 64'hDF0E_C987_B654_A321,
  parameter bit                      CLEAR_EN        = 1'b0,
  parameter logic [3:0]              CLEAR_CODE      = 4'hE
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [COLS-1:0]         i_cols,
  output logic [ROWS-1:0]         o_rows,
  output logic [NUM_DIGITS*4-1:0] o_digits,
  output logic                    o_key_valid,
  output logic [3:0]              o_key_code,
  output logic                    o_key_held
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SCW = $clog2(SCAN_DIV) + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  logic [COLS-1:0]         r_colsMeta;
  logic [COLS-1:0]         r_colsSync;
  state_t                  r_state;
  logic [RW-1:0]           r_rowIdx;
  logic [ROWS-1:0]         r_rows;
  logic [SCW-1:0]          r_scanCnt;
  logic [DBW-1:0]          r_dbCnt;
  logic [CW-1:0]           r_latCol;
  logic [COLS-1:0]         r_latPattern;
  logic [NUM_DIGITS*4-1:0] r_digits;
  logic                    r_keyValid;
  logic [3:0]              r_keyCode;
  logic                    r_keyHeld;

  logic                    w_idle;
  logic [COLS-1:0]         w_lowMask;
  logic                    w_single;
  logic [CW-1:0]           w_colIdx;
  logic [3:0]              w_code;
  logic [RW-1:0]           w_nextRow;
  logic [ROWS-1:0]         w_nextRows;
  logic [NUM_DIGITS*4-1:0] w_shifted;
  logic [NUM_DIGITS*4-1:0] w_newDigits;

  // Synchroniser resets to all-ones so the first samples after reset read as idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_colsMeta <= '1;
      r_colsSync <= '1;
    end else begin
      r_colsMeta <= i_cols;
      r_colsSync <= r_colsMeta;
    end
  end

  assign w_idle    = &r_colsSync;
  assign w_lowMask = ~r_colsSync;
  assign w_single  = (w_lowMask != '0) && ((w_lowMask & (w_lowMask - COLS'(1))) == '0);

  always_comb begin
    w_colIdx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_lowMask[c]) w_colIdx = CW'(c);
    end
  end

  always_comb begin
    int idx;
    idx    = int'(r_rowIdx) * COLS + int'(r_latCol);
    w_code = KEYMAP[idx*4 +: 4];
  end

  assign w_nextRow  = (r_rowIdx == ROW_LAST) ? '0 : r_rowIdx + RW'(1);
  assign w_nextRows = ~(ROWS'(1) << w_nextRow);

  generate
    if (NUM_DIGITS == 1) begin : g_replace
      assign w_shifted = w_code;
    end else begin : g_shift
      assign w_shifted = {r_digits[NUM_DIGITS*4-5:0], w_code};
    end
  endgenerate

  assign w_newDigits = (CLEAR_EN && (w_code == CLEAR_CODE)) ? '0 : w_shifted;

  // Scan / debounce / hold / release controller; all outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_SCAN;
      r_rowIdx     <= '0;
      r_rows       <= ~ROWS'(1);
      r_scanCnt    <= '0;
      r_dbCnt      <= '0;
      r_latCol     <= '0;
      r_latPattern <= '1;
      r_digits     <= '0;
      r_keyValid   <= 1'b0;
      r_keyCode    <= '0;
      r_keyHeld    <= 1'b0;
    end else begin
      r_keyValid <= 1'b0;
      case (r_state)
        S_SCAN: begin
          if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt <= '0;
            if (w_single) begin
              r_latCol     <= w_colIdx;
              r_latPattern <= r_colsSync;
              r_dbCnt      <= '0;
              r_state      <= S_DEBOUNCE;
            end else begin
              r_rowIdx <= w_nextRow;
              r_rows   <= w_nextRows;
            end
          end else begin
            r_scanCnt <= r_scanCnt + SCW'(1);
          end
        end

        S_DEBOUNCE: begin
          if (r_colsSync == r_latPattern) begin
            if (r_dbCnt == DB_LAST) begin
              r_dbCnt    <= '0;
              r_keyValid <= 1'b1;
              r_keyCode  <= w_code;
              r_digits   <= w_newDigits;
              r_keyHeld  <= 1'b1;
              r_state    <= S_HELD;
            end else begin
              r_dbCnt <= r_dbCnt + DBW'(1);
            end
          end else begin
            r_dbCnt   <= '0;
            r_scanCnt <= '0;
            r_rowIdx  <= w_nextRow;
            r_rows    <= w_nextRows;
            r_state   <= S_SCAN;
          end
        end

        S_HELD: begin
          if (w_idle) begin
            r_dbCnt <= '0;
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Any low column restarts the release window; no new press can be taken here.
          if (w_idle) begin
            if (r_dbCnt == DB_LAST) begin
              r_dbCnt   <= '0;
              r_keyHeld <= 1'b0;
              r_scanCnt <= '0;
              r_rowIdx  <= w_nextRow;
              r_rows    <= w_nextRows;
              r_state   <= S_SCAN;
            end else begin
              r_dbCnt <= r_dbCnt + DBW'(1);
            end
          end else begin
            r_dbCnt <= '0;
          end
        end

        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign o_rows      = r_rows;
  assign o_digits    = r_digits;
  assign o_key_valid = r_keyValid;
  assign o_key_code  = r_keyCode;
  assign o_key_held  = r_keyHeld;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Directed bench for keypad_digit_buffer: three instances (default, clear-enabled,
// four-digit) share one simulated keypad so every press is checked on all of them.
module tb_keypad_digit_buffer;

  typedef struct {
    int          row;
    int          col;
    int          hold;
    logic [3:0]  code;
    logic [7:0]  dig;
    logic [7:0]  digClr;
    logic [15:0] dig4;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keyDown = '0;
  logic [3:0]  forceLow = '0;

  logic [3:0]  colsMain, colsClr, cols4;
  logic [3:0]  rowsMain, rowsClr, rows4;
  logic [7:0]  digMain, digClr;
  logic [15:0] dig4;
  logic        validMain, validClr, valid4;
  logic [3:0]  codeMain, codeClr, code4;
  logic        heldMain, heldClr, held4;

  int checks = 0;
  int errors = 0;
  int evMain = 0;
  int evClr  = 0;
  int ev4    = 0;

  vec_t vecs[11];

  always #5 clk = ~clk;

  function automatic logic [3:0] colsFor(input logic [3:0] rows, input logic [15:0] keys,
                                         input logic [3:0] lowMask);
    logic [3:0] res;
    res = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) res[c] = 1'b0;
    return res & ~lowMask;
  endfunction

  assign colsMain = colsFor(rowsMain, keyDown, forceLow);
  assign colsClr  = colsFor(rowsClr, keyDown, forceLow);
  assign cols4    = colsFor(rows4, keyDown, forceLow);

  keypad_digit_buffer #(.NUM_DIGITS(2), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .CLEAR_EN(1'b0)) dutMain (
    .i_clk(clk), .i_rst_n(rst_n), .i_cols(colsMain), .o_rows(rowsMain), .o_digits(digMain),
    .o_key_valid(validMain), .o_key_code(codeMain), .o_key_held(heldMain));

  keypad_digit_buffer #(.NUM_DIGITS(2), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .CLEAR_EN(1'b1)) dutClr (
    .i_clk(clk), .i_rst_n(rst_n), .i_cols(colsClr), .o_rows(rowsClr), .o_digits(digClr),
    .o_key_valid(validClr), .o_key_code(codeClr), .o_key_held(heldClr));

  keypad_digit_buffer #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .CLEAR_EN(1'b0)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cols(cols4), .o_rows(rows4), .o_digits(dig4),
    .o_key_valid(valid4), .o_key_code(code4), .o_key_held(held4));

  // Each key_valid cycle seen on the falling edge counts as one event.
  always @(negedge clk) begin
    if (validMain) evMain++;
    if (validClr)  evClr++;
    if (valid4)    ev4++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press one key, hold it, release it, let release debounce finish, then compare.
  task automatic applyStimulus(input vec_t v, input int idx);
    int b0, b1, b2;
    b0 = evMain; b1 = evClr; b2 = ev4;
    keyDown[v.row*4+v.col] = 1'b1;
    waitClks(v.hold);
    checkOutput($sformatf("v%0d held_during", idx), 32'(heldMain), 32'd1);
    keyDown = '0;
    waitClks(40);
    checkOutput($sformatf("v%0d events_main", idx), 32'(evMain - b0), 32'd1);
    checkOutput($sformatf("v%0d events_clr", idx), 32'(evClr - b1), 32'd1);
    checkOutput($sformatf("v%0d events_4", idx), 32'(ev4 - b2), 32'd1);
    checkOutput($sformatf("v%0d code_main", idx), 32'(codeMain), 32'(v.code));
    checkOutput($sformatf("v%0d code_clr", idx), 32'(codeClr), 32'(v.code));
    checkOutput($sformatf("v%0d digits_main", idx), 32'(digMain), 32'(v.dig));
    checkOutput($sformatf("v%0d digits_clr", idx), 32'(digClr), 32'(v.digClr));
    checkOutput($sformatf("v%0d digits_4", idx), 32'(dig4), 32'(v.dig4));
    checkOutput($sformatf("v%0d held_after", idx), 32'(heldMain), 32'd0);
  endtask

  initial begin
    int b0, b1, b2;
    logic [3:0] seen;

    vecs[0]  = '{1, 1, 100, 4'h5, 8'h05, 8'h05, 16'h0005};
    vecs[1]  = '{2, 2, 100, 4'h9, 8'h59, 8'h59, 16'h0059};
    vecs[2]  = '{0, 3, 100, 4'hA, 8'h9A, 8'h9A, 16'h059A};
    vecs[3]  = '{1, 1, 100, 4'h5, 8'h95, 8'h95, 16'h0095};
    vecs[4]  = '{2, 2, 100, 4'h9, 8'h59, 8'h59, 16'h0959};
    vecs[5]  = '{3, 0, 100, 4'hE, 8'h9E, 8'h00, 16'h959E};
    vecs[6]  = '{0, 0, 100, 4'h1, 8'hE1, 8'h01, 16'h59E1};
    vecs[7]  = '{0, 1, 100, 4'h2, 8'h12, 8'h12, 16'h9E12};
    vecs[8]  = '{0, 2, 100, 4'h3, 8'h23, 8'h23, 16'hE123};
    vecs[9]  = '{1, 0, 100, 4'h4, 8'h34, 8'h34, 16'h1234};
    vecs[10] = '{1, 1, 100, 4'h5, 8'h45, 8'h45, 16'h2345};

    // Reset values and the idle row-scan sequence.
    waitClks(3);
    checkOutput("reset digits", 32'(digMain), 32'h00);
    checkOutput("reset valid", 32'(validMain), 32'd0);
    checkOutput("reset held", 32'(heldMain), 32'd0);
    checkOutput("reset code", 32'(codeMain), 32'd0);
    checkOutput("reset rows", 32'(rowsMain), 32'hE);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] expRows;
      expRows = ~(4'd1 << ((i / 4) % 4));
      checkOutput($sformatf("scan rows t%0d", i), 32'(rowsMain), 32'(expRows));
      @(negedge clk);
    end

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i);

    // Column 0 bouncing every 3 clks never reaches a stable debounce window.
    b0 = evMain;
    for (int i = 0; i < 14; i++) begin
      forceLow[0] = ~forceLow[0];
      waitClks(3);
    end
    forceLow = '0;
    waitClks(40);
    checkOutput("bounce events", 32'(evMain - b0), 32'd0);
    checkOutput("bounce digits", 32'(digMain), 32'h9A);
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      for (int r = 0; r < 4; r++) if (!rowsMain[r]) seen[r] = 1'b1;
      @(negedge clk);
    end
    checkOutput("bounce scan resumes", 32'(seen), 32'hF);

    // Two columns low on row 0 is rejected; dropping one leaves key '2'.
    b0 = evMain; b1 = evClr; b2 = ev4;
    keyDown[0] = 1'b1;
    keyDown[1] = 1'b1;
    waitClks(100);
    checkOutput("multikey events", 32'(evMain - b0), 32'd0);
    keyDown[0] = 1'b0;
    waitClks(100);
    keyDown = '0;
    waitClks(40);
    checkOutput("multikey then single events", 32'(evMain - b0), 32'd1);
    checkOutput("multikey code", 32'(codeMain), 32'h2);
    checkOutput("multikey digits_main", 32'(digMain), 32'hA2);
    checkOutput("multikey digits_4", 32'(dig4), 32'h59A2);

    // Long hold gives one event; a 3-clk glitch during release restarts the release window.
    b0 = evMain;
    keyDown[5] = 1'b1;
    waitClks(500);
    checkOutput("long hold events", 32'(evMain - b0), 32'd1);
    checkOutput("long hold held", 32'(heldMain), 32'd1);
    keyDown = '0;
    waitClks(4);
    keyDown[5] = 1'b1;
    waitClks(3);
    keyDown = '0;
    waitClks(6);
    checkOutput("glitch held stays", 32'(heldMain), 32'd1);
    waitClks(14);
    checkOutput("glitch held clears", 32'(heldMain), 32'd0);
    checkOutput("glitch events", 32'(evMain - b0), 32'd1);
    checkOutput("long hold digits_main", 32'(digMain), 32'h25);
    checkOutput("long hold digits_4", 32'(dig4), 32'h9A25);
    waitClks(20);

    // Reset while a key is held, then the still-held key is detected afresh.
    keyDown[10] = 1'b1;
    waitClks(60);
    checkOutput("pre-reset held", 32'(heldMain), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset digits", 32'(digMain), 32'h00);
    checkOutput("midreset held", 32'(heldMain), 32'd0);
    checkOutput("midreset code", 32'(codeMain), 32'd0);
    checkOutput("midreset rows", 32'(rowsMain), 32'hE);
    waitClks(3);
    b0 = evMain; b1 = evClr; b2 = ev4;
    rst_n = 1'b1;
    waitClks(100);
    checkOutput("post-reset events", 32'(evMain - b0), 32'd1);
    checkOutput("post-reset code", 32'(codeMain), 32'h9);
    checkOutput("post-reset digits_main", 32'(digMain), 32'h09);
    checkOutput("post-reset digits_4", 32'(dig4), 32'h0009);
    keyDown = '0;
    waitClks(40);
    checkOutput("post-reset single event", 32'(evMain - b0), 32'd1);

    for (int i = 3; i < 11; i++) applyStimulus(vecs[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
